// File: rtl/aes_inv_key_schedule.sv
// Reverse AES-128 key schedule: from the round-10 key, emits round keys 10..0,
// one per key_valid/key_ready handshake, undoing the forward expansion on the fly.

module sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_s
);
  // Entry 0 sits in the top byte, so S(x) lives at index 255-x == ~x.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign o_s = SBOX[~i_a];
endmodule

module aes_inv_key_schedule (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic [3:0][3:0][7:0] i_key_in,
  input  logic                 i_key_ready,
  output logic                 o_key_valid,
  output logic [3:0][3:0][7:0] o_key_out,
  output logic [3:0]           o_round_out,
  output logic                 o_busy,
  output logic                 o_done
);
  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t       r_state, w_next_state;
  logic [127:0] r_key;
  logic [3:0]   r_rnd;
  logic         r_done;

  logic [127:0] w_key_in_flat, w_inv;
  logic [31:0]  w_w0, w_w1, w_w2, w_w3;
  logic [31:0]  w_w0n, w_w1n, w_w2n, w_w3n;
  logic [31:0]  w_rot, w_sub;
  logic [7:0]   w_rcon;
  logic         w_load, w_accept;

  // Column c is word w_c, row 0 the word's MSB byte; w0 occupies bits 127:96.
  always_comb begin
    w_key_in_flat = '0;
    o_key_out     = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_key_in_flat[127-32*c-8*r -: 8] = i_key_in[r][c];
        o_key_out[r][c]                  = r_key[127-32*c-8*r -: 8];
      end
    end
  end

  assign {w_w0, w_w1, w_w2, w_w3} = r_key;
  assign w_w3n = w_w3 ^ w_w2;
  assign w_w2n = w_w2 ^ w_w1;
  assign w_w1n = w_w1 ^ w_w0;
  assign w_rot = {w_w3n[23:0], w_w3n[31:24]};

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_sub
      sbox u_sbox (.i_a(w_rot[8*g +: 8]), .o_s(w_sub[8*g +: 8]));
    end
  endgenerate

  always_comb begin
    case (r_rnd)
      4'd1:    w_rcon = 8'h01;
      4'd2:    w_rcon = 8'h02;
      4'd3:    w_rcon = 8'h04;
      4'd4:    w_rcon = 8'h08;
      4'd5:    w_rcon = 8'h10;
      4'd6:    w_rcon = 8'h20;
      4'd7:    w_rcon = 8'h40;
      4'd8:    w_rcon = 8'h80;
      4'd9:    w_rcon = 8'h1b;
      4'd10:   w_rcon = 8'h36;
      default: w_rcon = 8'h00;
    endcase
  end

  assign w_w0n = w_w0 ^ w_sub ^ {w_rcon, 24'h0};
  assign w_inv = {w_w0n, w_w1n, w_w2n, w_w3n};

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_next_state = S_ACTIVE;
      S_ACTIVE: if (i_key_ready && r_rnd == 4'd0) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    o_key_valid = (r_state == S_ACTIVE);
    o_busy      = (r_state == S_ACTIVE);
    w_load      = (r_state == S_IDLE) && i_start;
    w_accept    = (r_state == S_ACTIVE) && i_key_ready;
  end

  // After round 0 is accepted K and rnd are left holding the round-0 key.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_key  <= '0;
      r_rnd  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_accept && (r_rnd == 4'd0);
      if (w_load) begin
        r_key <= w_key_in_flat;
        r_rnd <= 4'd10;
      end else if (w_accept && r_rnd != 4'd0) begin
        r_key <= w_inv;
        r_rnd <= r_rnd - 4'd1;
      end
    end
  end

  assign o_round_out = r_rnd;
  assign o_done      = r_done;
endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Directed and round-trip bench for aes_inv_key_schedule.

module tb_aes_inv_key_schedule;
  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 i_start = 1'b0;
  logic [3:0][3:0][7:0] i_key_in = '0;
  logic                 i_key_ready = 1'b0;
  logic                 o_key_valid;
  logic [3:0][3:0][7:0] o_key_out;
  logic [3:0]           o_round_out;
  logic                 o_busy;
  logic                 o_done;

  aes_inv_key_schedule dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_key_in(i_key_in),
    .i_key_ready(i_key_ready), .o_key_valid(o_key_valid), .o_key_out(o_key_out),
    .o_round_out(o_round_out), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] A1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] A1_R9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] A1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_R0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] Z_R9   = 128'h55636363000000000000000000000000;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sb [256];
  logic [127:0] exp_key [11];
  logic [127:0] got_key [11];
  logic [3:0]   got_rnd [11];
  int           n_acc;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d = {v, v};
    return d[15-n -: 8];
  endfunction

  // S-box built from first principles: GF(2^8) inverse plus affine map.
  task automatic init_sbox;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // Forward expansion of a cipher key into exp_key[0..10].
  task automatic fwd_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [7:0]  rc = 8'h01;
    {w[0], w[1], w[2], w[3]} = k;
    for (int i = 4; i < 44; i++) begin
      logic [31:0] t = w[i-1];
      if (i % 4 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_key[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [3:0][3:0][7:0] to_arr(input logic [127:0] f);
    logic [3:0][3:0][7:0] a = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) a[r][c] = f[127-32*c-8*r -: 8];
    return a;
  endfunction

  function automatic logic [127:0] to_flat(input logic [3:0][3:0][7:0] a);
    logic [127:0] f = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) f[127-32*c-8*r -: 8] = a[r][c];
    return f;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [127:0] k);
    i_key_in = to_arr(k);
    i_start  = 1'b1;
    step();
    i_start  = 1'b0;
  endtask

  // Drains the running sequence, recording every accepted key; checks hold
  // stability under backpressure and optionally pulses start at one round.
  task automatic collect(input bit rand_ready, input int start_at, input logic [127:0] alt);
    int           cyc = 0;
    bit           held = 1'b0;
    logic [127:0] prev_k = '0;
    logic [3:0]   prev_r = '0;
    n_acc = 0;
    while (o_key_valid && cyc < 200) begin
      logic rdy;
      if (held) begin
        checks++;
        if (to_flat(o_key_out) !== prev_k || o_round_out !== prev_r) begin
          errors++;
          $display("FAIL hold_stable: got %h/%0d required %h/%0d",
                   to_flat(o_key_out), o_round_out, prev_k, prev_r);
        end
      end
      rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      i_key_ready = rdy;
      i_start = (start_at >= 0 && int'(o_round_out) == start_at) ? 1'b1 : 1'b0;
      if (i_start) i_key_in = to_arr(alt);
      if (rdy && n_acc < 11) begin
        got_key[n_acc] = to_flat(o_key_out);
        got_rnd[n_acc] = o_round_out;
      end
      if (rdy) n_acc++;
      held   = !rdy;
      prev_k = to_flat(o_key_out);
      prev_r = o_round_out;
      step();
      cyc++;
    end
    i_key_ready = 1'b0;
    i_start     = 1'b0;
    checks++;
    if (cyc >= 200) begin
      errors++;
      $display("FAIL collect_timeout: got %0d cycles required < 200", cyc);
    end
  endtask

  task automatic check_seq(input string name);
    checks++;
    if (n_acc !== 11) begin
      errors++;
      $display("FAIL %s_count: got %0d required 11", name, n_acc);
    end
    for (int j = 0; j < 11 && j < n_acc; j++) begin
      checks++;
      if (got_key[j] !== exp_key[10-j] || got_rnd[j] !== 4'(10-j)) begin
        errors++;
        $display("FAIL %s_round%0d: got %h/%0d required %h/%0d",
                 name, 10-j, got_key[j], got_rnd[j], exp_key[10-j], 10-j);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; i_start = 1'b1; i_key_ready = 1'b1; i_key_in = to_arr(A1_R10);
    step(); step();
    checks++;
    if (o_key_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 ||
        to_flat(o_key_out) !== 128'h0 || o_round_out !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: got v%b b%b d%b %h r%0d required all zero",
               o_key_valid, o_busy, o_done, to_flat(o_key_out), o_round_out);
    end
    reset = 1'b0; i_start = 1'b0; i_key_ready = 1'b0;
    step();
    checks++;
    if (o_key_valid !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got v%b b%b required 0 0", o_key_valid, o_busy);
    end
  endtask

  task automatic test_fips;
    fwd_expand(A1_R0);
    load(A1_R10);
    collect(1'b0, -1, '0);
    check_seq("fips");
    checks++;
    if (got_key[0] !== A1_R10 || got_key[1] !== A1_R9 ||
        got_key[9] !== A1_R1 || got_key[10] !== A1_R0) begin
      errors++;
      $display("FAIL fips_vectors: got %h %h %h %h required %h %h %h %h",
               got_key[0], got_key[1], got_key[9], got_key[10], A1_R10, A1_R9, A1_R1, A1_R0);
    end
    checks++;
    if (o_done !== 1'b1 || o_busy !== 1'b0 || o_key_valid !== 1'b0) begin
      errors++;
      $display("FAIL fips_done: got d%b b%b v%b required 1 0 0", o_done, o_busy, o_key_valid);
    end
    step();
    checks++;
    if (o_done !== 1'b0 || to_flat(o_key_out) !== A1_R0 || o_round_out !== 4'd0) begin
      errors++;
      $display("FAIL fips_after: got d%b %h r%0d required 0 %h 0",
               o_done, to_flat(o_key_out), o_round_out, A1_R0);
    end
  endtask

  task automatic test_backpressure;
    load(A1_R10);
    collect(1'b1, -1, '0);
    check_seq("bp");
    step();
  endtask

  task automatic test_start_busy;
    load(A1_R10);
    collect(1'b0, 6, 128'hffeeddccbbaa99887766554433221100);
    check_seq("startbusy");
    step();
  endtask

  task automatic test_reset_mid;
    int cyc = 0;
    load(A1_R10);
    i_key_ready = 1'b1;
    while (o_round_out !== 4'd4 && cyc < 20) begin
      step();
      cyc++;
    end
    reset = 1'b1; i_start = 1'b1; i_key_in = to_arr(A1_R10);
    step();
    reset = 1'b0; i_start = 1'b0; i_key_ready = 1'b0;
    checks++;
    if (o_key_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 ||
        to_flat(o_key_out) !== 128'h0 || o_round_out !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid: got v%b b%b d%b %h r%0d required all zero",
               o_key_valid, o_busy, o_done, to_flat(o_key_out), o_round_out);
    end
    step();
    checks++;
    if (o_done !== 1'b0 || o_key_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_nodone: got d%b v%b required 0 0", o_done, o_key_valid);
    end
    load(A1_R10);
    checks++;
    if (o_key_valid !== 1'b1 || o_round_out !== 4'd10 || to_flat(o_key_out) !== A1_R10) begin
      errors++;
      $display("FAIL reset_mid_reload: got v%b r%0d %h required 1 10 %h",
               o_key_valid, o_round_out, to_flat(o_key_out), A1_R10);
    end
    collect(1'b0, -1, '0);
    check_seq("reset_restart");
    step();
  endtask

  task automatic test_back_to_back;
    load(A1_R10);
    collect(1'b0, -1, '0);
    checks++;
    if (o_done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: got %b required 1", o_done);
    end
    i_key_in = '0;
    i_start  = 1'b1;
    step();
    i_start  = 1'b0;
    checks++;
    if (o_key_valid !== 1'b1 || o_busy !== 1'b1 || o_round_out !== 4'd10 ||
        to_flat(o_key_out) !== 128'h0) begin
      errors++;
      $display("FAIL b2b_load: got v%b b%b r%0d %h required 1 1 10 0",
               o_key_valid, o_busy, o_round_out, to_flat(o_key_out));
    end
    collect(1'b0, -1, '0);
    checks++;
    if (n_acc !== 11 || got_key[1] !== Z_R9 || got_rnd[1] !== 4'd9) begin
      errors++;
      $display("FAIL b2b_round9: got n%0d %h r%0d required 11 %h 9",
               n_acc, got_key[1], got_rnd[1], Z_R9);
    end
    step();
  endtask

  task automatic test_roundtrip;
    for (int t = 0; t < 100; t++) begin
      logic [127:0] k = {$urandom, $urandom, $urandom, $urandom};
      fwd_expand(k);
      load(exp_key[10]);
      collect(t[0], -1, '0);
      check_seq("roundtrip");
      step();
    end
  endtask

  initial begin
    init_sbox();
    test_reset();
    test_fips();
    test_backpressure();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    test_roundtrip();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
